// File: rtl/hilo_unit.sv
// hilo_unit: HI/LO register pair with MTxx, multiply, multiply-accumulate and
// a restoring 1-bit/cycle divider that raises busy while it iterates.
module hilo_unit #(
    parameter int WIDTH  = 32,
    parameter bit EN_MAC = 1'b1
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             op_valid,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic             flush,
    output logic             busy,
    output logic             div_done,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);
    localparam logic [3:0] OP_MTHI  = 4'd1;
    localparam logic [3:0] OP_MTLO  = 4'd2;
    localparam logic [3:0] OP_MULT  = 4'd3;
    localparam logic [3:0] OP_MULTU = 4'd4;
    localparam logic [3:0] OP_DIV   = 4'd5;
    localparam logic [3:0] OP_DIVU  = 4'd6;
    localparam logic [3:0] OP_MADD  = 4'd7;
    localparam logic [3:0] OP_MADDU = 4'd8;
    localparam logic [3:0] OP_MSUB  = 4'd9;
    localparam logic [3:0] OP_MSUBU = 4'd10;
    localparam int         CW       = $clog2(WIDTH + 1);

    logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d, rem_q, rem_d, quo_q, quo_d;
    logic [WIDTH-1:0]   dvs_q, dvs_d, araw_q, araw_d;
    logic               busy_q, busy_d, done_q, done_d;
    logic               qneg_q, qneg_d, rneg_q, rneg_d, dz_q, dz_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [2*WIDTH-1:0] prod_s, prod_u, prod, acc;
    logic [WIDTH:0]     trial;
    logic [WIDTH-1:0]   step_rem, step_quo, a_mag, b_mag;
    logic               sgn_div;

    // Sign-extending to 2*WIDTH makes the truncated unsigned product the signed one
    assign prod_u   = {{WIDTH{1'b0}}, src_a} * {{WIDTH{1'b0}}, src_b};
    assign prod_s   = {{WIDTH{src_a[WIDTH-1]}}, src_a} * {{WIDTH{src_b[WIDTH-1]}}, src_b};
    assign prod     = (op == OP_MULT || op == OP_MADD || op == OP_MSUB) ? prod_s : prod_u;
    assign acc      = {hi_q, lo_q};
    assign sgn_div  = op == OP_DIV;
    assign a_mag    = (sgn_div && src_a[WIDTH-1]) ? -src_a : src_a;
    assign b_mag    = (sgn_div && src_b[WIDTH-1]) ? -src_b : src_b;
    assign trial    = {rem_q, quo_q[WIDTH-1]} - {1'b0, dvs_q};
    assign step_rem = trial[WIDTH] ? {rem_q[WIDTH-2:0], quo_q[WIDTH-1]} : trial[WIDTH-1:0];
    assign step_quo = {quo_q[WIDTH-2:0], ~trial[WIDTH]};

    always_comb begin
        hi_d   = hi_q;
        lo_d   = lo_q;
        rem_d  = rem_q;
        quo_d  = quo_q;
        dvs_d  = dvs_q;
        araw_d = araw_q;
        busy_d = busy_q;
        done_d = 1'b0;
        qneg_d = qneg_q;
        rneg_d = rneg_q;
        dz_d   = dz_q;
        cnt_d  = cnt_q;
        if (flush) begin
            busy_d = 1'b0;
            cnt_d  = '0;
        end else if (busy_q) begin
            cnt_d = cnt_q - CW'(1);
            rem_d = step_rem;
            quo_d = step_quo;
            if (cnt_q == CW'(1)) begin
                busy_d = 1'b0;
                done_d = 1'b1;
                lo_d   = dz_q ? '1 : (qneg_q ? -step_quo : step_quo);
                hi_d   = dz_q ? araw_q : (rneg_q ? -step_rem : step_rem);
            end
        end else if (op_valid) begin
            case (op)
                OP_MTHI:           hi_d = src_a;
                OP_MTLO:           lo_d = src_a;
                OP_MULT, OP_MULTU: {hi_d, lo_d} = prod;
                OP_MADD, OP_MADDU: if (EN_MAC) {hi_d, lo_d} = acc + prod;
                OP_MSUB, OP_MSUBU: if (EN_MAC) {hi_d, lo_d} = acc - prod;
                OP_DIV, OP_DIVU: begin
                    rem_d  = '0;
                    quo_d  = a_mag;
                    dvs_d  = b_mag;
                    araw_d = src_a;
                    qneg_d = sgn_div & (src_a[WIDTH-1] ^ src_b[WIDTH-1]);
                    rneg_d = sgn_div & src_a[WIDTH-1];
                    dz_d   = src_b == '0;
                    cnt_d  = CW'(WIDTH);
                    busy_d = 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            hi_q   <= '0;
            lo_q   <= '0;
            rem_q  <= '0;
            quo_q  <= '0;
            dvs_q  <= '0;
            araw_q <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            qneg_q <= 1'b0;
            rneg_q <= 1'b0;
            dz_q   <= 1'b0;
            cnt_q  <= '0;
        end else begin
            hi_q   <= hi_d;
            lo_q   <= lo_d;
            rem_q  <= rem_d;
            quo_q  <= quo_d;
            dvs_q  <= dvs_d;
            araw_q <= araw_d;
            busy_q <= busy_d;
            done_q <= done_d;
            qneg_q <= qneg_d;
            rneg_q <= rneg_d;
            dz_q   <= dz_d;
            cnt_q  <= cnt_d;
        end
    end

    assign busy     = busy_q;
    assign div_done = done_q;
    assign hi_o     = hi_q;
    assign lo_o     = lo_q;
endmodule

// File: tb/tb_hilo_unit.sv
// tb_hilo_unit: directed stimulus against an arithmetic reference model of hilo_unit.
module tb_hilo_unit;
    localparam logic [3:0] MTHI = 4'd1, MTLO = 4'd2, MULT = 4'd3, MULTU = 4'd4;
    localparam logic [3:0] DIV = 4'd5, DIVU = 4'd6, MADD = 4'd7, MADDU = 4'd8;
    localparam logic [3:0] MSUB = 4'd9, MSUBU = 4'd10;

    logic        clk = 1'b0, resetn = 1'b0, op_valid = 1'b0, flush = 1'b0;
    logic [3:0]  op = 4'd0;
    logic [31:0] src_a = '0, src_b = '0;
    logic        busy, div_done, busy2, done2;
    logic [31:0] hi, lo, hi2, lo2;
    int          n_chk = 0, n_fail = 0;

    hilo_unit #(.WIDTH(32), .EN_MAC(1'b1)) dut (
        .clk(clk), .resetn(resetn), .op_valid(op_valid), .op(op), .src_a(src_a),
        .src_b(src_b), .flush(flush), .busy(busy), .div_done(div_done), .hi_o(hi), .lo_o(lo));

    hilo_unit #(.WIDTH(32), .EN_MAC(1'b0)) dut_nomac (
        .clk(clk), .resetn(resetn), .op_valid(op_valid), .op(op), .src_a(src_a),
        .src_b(src_b), .flush(flush), .busy(busy2), .div_done(done2), .hi_o(hi2), .lo_o(lo2));

    always #5 clk = ~clk;

    // Reference model: results from plain integer arithmetic, divide latency as a countdown
    logic [31:0] m_hi = '0, m_lo = '0, p_hi = '0, p_lo = '0;
    logic [63:0] t64, prd;
    longint      sa, sb;
    int          m_left = 0;
    logic        m_done = 1'b0;

    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            m_hi = '0; m_lo = '0; m_left = 0; m_done = 1'b0;
        end else begin
            m_done = 1'b0;
            if (flush) m_left = 0;
            else if (m_left > 0) begin
                m_left--;
                if (m_left == 0) begin
                    m_hi = p_hi; m_lo = p_lo; m_done = 1'b1;
                end
            end else if (op_valid) begin
                sa  = longint'($signed(src_a));
                sb  = longint'($signed(src_b));
                prd = (op == MULT || op == MADD || op == MSUB) ? 64'(sa * sb) : {32'b0, src_a} * {32'b0, src_b};
                case (op)
                    MTHI:         m_hi = src_a;
                    MTLO:         m_lo = src_a;
                    MULT, MULTU:  {m_hi, m_lo} = prd;
                    MADD, MADDU:  {m_hi, m_lo} = {m_hi, m_lo} + prd;
                    MSUB, MSUBU:  {m_hi, m_lo} = {m_hi, m_lo} - prd;
                    DIV, DIVU: begin
                        if (src_b == 0) begin
                            p_lo = '1; p_hi = src_a;
                        end else if (op == DIV) begin
                            t64 = 64'(sa / sb); p_lo = t64[31:0];
                            t64 = 64'(sa % sb); p_hi = t64[31:0];
                        end else begin
                            p_lo = src_a / src_b; p_hi = src_a % src_b;
                        end
                        m_left = 32;
                    end
                    default: ;
                endcase
            end
        end
    end

    always @(negedge clk) begin
        n_chk++;
        if ({busy, div_done, hi, lo} !== {m_left > 0, m_done, m_hi, m_lo}) begin
            n_fail++;
            $display("FAIL model t=%0t: busy=%b done=%b hi=%h lo=%h expected busy=%b done=%b hi=%h lo=%h",
                     $time, busy, div_done, hi, lo, m_left > 0, m_done, m_hi, m_lo);
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
        op_valid = 1'b1; op = o; src_a = a; src_b = b;
        sync();
        op_valid = 1'b0;
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (busy && n < 100) begin
            n++;
            sync();
        end
        chk("div_terminates", 32'(busy), 32'd0);
    endtask

    initial begin
        int n, pulses;
        repeat (2) @(posedge clk);
        #1 resetn = 1'b1;
        sync(); #1;
        chk("reset_hi", hi, 32'h0);
        chk("reset_lo", lo, 32'h0);
        chk("reset_busy", 32'(busy), 32'h0);

        issue(MTHI, 32'h12345678, 32'h0);
        issue(MTLO, 32'h9ABCDEF0, 32'h0); #1;
        chk("mthi", hi, 32'h12345678);
        chk("mtlo", lo, 32'h9ABCDEF0);
        resetn = 1'b0; #1;
        chk("async_rst_hi", hi, 32'h0);
        chk("async_rst_lo", lo, 32'h0);
        sync(); resetn = 1'b1; sync();

        issue(MULT, 32'hFFFFFFFD, 32'd5); #1;
        chk("mult_hi", hi, 32'hFFFFFFFF);
        chk("mult_lo", lo, 32'hFFFFFFF1);
        issue(MULTU, 32'hFFFFFFFD, 32'd5); #1;
        chk("multu_hi", hi, 32'h00000004);
        chk("multu_lo", lo, 32'hFFFFFFF1);

        issue(MTHI, 32'hFFFFFFFF, 0);
        issue(MTLO, 32'hFFFFFFFF, 0);
        issue(MADDU, 32'd1, 32'd1); #1;
        chk("maddu_wrap_hi", hi, 32'h0);
        chk("maddu_wrap_lo", lo, 32'h0);
        chk("nomac_hi", hi2, 32'hFFFFFFFF);
        chk("nomac_lo", lo2, 32'hFFFFFFFF);
        issue(MTHI, 32'h0, 0);
        issue(MTLO, 32'd10, 0);
        issue(MSUB, 32'd2, 32'd3); #1;
        chk("msub_hi", hi, 32'h0);
        chk("msub_lo", lo, 32'd4);
        issue(MADD, 32'hFFFFFFFE, 32'd3); #1;
        chk("madd_neg_lo", lo, 32'hFFFFFFFE);
        issue(MSUBU, 32'h80000000, 32'd4); #1;
        chk("msubu_hi", hi, 32'hFFFFFFFD);
        issue(MADD, 32'h7, 32'h1);

        issue(DIV, 32'hFFFFFFF9, 32'd2);
        n = 0;
        while (busy && n < 100) begin
            n++;
            if (n == 5) begin
                op_valid = 1'b1; op = MTHI; src_a = 32'hDEADBEEF;
            end else op_valid = 1'b0;
            sync();
        end
        op_valid = 1'b0; #1;
        chk("div_busy_cycles", n, 32'd32);
        chk("div_done_pulse", 32'(div_done), 32'd1);
        chk("div_lo", lo, 32'hFFFFFFFD);
        chk("div_hi", hi, 32'hFFFFFFFF);

        issue(DIVU, 32'd100, 32'd0); wait_idle(n); #1;
        chk("divu_zero_lo", lo, 32'hFFFFFFFF);
        chk("divu_zero_hi", hi, 32'd100);
        issue(DIV, 32'hFFFFFFF9, 32'd0); wait_idle(n); #1;
        chk("div_zero_raw_hi", hi, 32'hFFFFFFF9);
        issue(DIV, 32'h80000000, 32'hFFFFFFFF); wait_idle(n); #1;
        chk("div_ovf_lo", lo, 32'h80000000);
        chk("div_ovf_hi", hi, 32'h0);
        issue(DIV, 32'd7, 32'hFFFFFFFE); wait_idle(n);
        issue(DIVU, 32'hFFFFFFF9, 32'd10); wait_idle(n); #1;
        chk("divu_big_lo", lo, 32'h19999998);
        chk("divu_big_hi", hi, 32'd9);

        issue(MTHI, 32'hAAAA0000, 0);
        issue(MTLO, 32'h00005555, 0);
        issue(DIVU, 32'd1000, 32'd7);
        repeat (9) sync();
        flush = 1'b1;
        sync();
        flush = 1'b0; #1;
        chk("flush_busy", 32'(busy), 32'd0);
        chk("flush_hi", hi, 32'hAAAA0000);
        chk("flush_lo", lo, 32'h00005555);
        pulses = 0;
        repeat (40) begin
            sync();
            if (div_done) pulses++;
        end
        chk("flush_no_done", pulses, 32'd0);

        flush = 1'b1;
        issue(MTHI, 32'h11111111, 0);
        flush = 1'b0; #1;
        chk("flush_idle_hi", hi, 32'hAAAA0000);

        sync();
        issue(DIV, 32'd1000, 32'd3);
        repeat (5) sync();
        resetn = 1'b0; #1;
        chk("rst_mid_busy", 32'(busy), 32'd0);
        chk("rst_mid_hi", hi, 32'h0);
        chk("rst_mid_lo", lo, 32'h0);
        sync(); resetn = 1'b1; sync();
        issue(DIV, 32'd1000, 32'hFFFFFFF9); wait_idle(n); #1;
        chk("div_after_rst_lo", lo, 32'hFFFFFF72);
        chk("div_after_rst_hi", hi, 32'd6);

        repeat (3) sync();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
